// File: rtl/stream_source_fifo_if.sv
// Handshake bundle around the stream source FIFO: a producer write port and a
// first-word-fall-through output port toward the downstream stage.
interface stream_source_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  stream_in_valid;
    logic                  stream_in_ready;
    logic [DATA_WIDTH-1:0] stream_in_data;

    // Handshake rule on both ports: a word moves on a rising clk edge where
    // valid && ready; ready never depends on valid, and a valid word holds
    // its data until it is taken.

    // master: the FIFO itself (accepts writes, drives the output stream)
    modport master (
        input  wr_valid,
        input  wr_data,
        output wr_ready,
        output stream_in_valid,
        output stream_in_data,
        input  stream_in_ready
    );

    // slave: the surrounding producer/consumer pair
    modport slave (
        output wr_valid,
        output wr_data,
        input  wr_ready,
        input  stream_in_valid,
        input  stream_in_data,
        output stream_in_ready
    );
endinterface

// File: rtl/stream_source_fifo.sv
// Small first-word-fall-through FIFO feeding a downstream stream stage, with
// occupancy, transfer counter and a sticky flag for writes attempted while full.
module stream_source_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    stream_source_fifo_if.master     bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              xfer_count,
    output logic                     stall_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // Flow control comes only from registered occupancy, never from the
    // downstream ready, so a full FIFO refuses writes even while draining.
    assign bus.wr_ready        = !full;
    assign bus.stream_in_valid = !empty;
    assign bus.stream_in_data  = empty ? '0 : mem[rd_ptr];

    assign do_wr = bus.wr_valid && !full;
    assign do_rd = !empty && bus.stream_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            xfer_count <= '0;
            stall_seen <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                xfer_count <= xfer_count + 16'd1;
            end
            if (do_wr && !do_rd)      level <= level + LVL_ONE;
            else if (do_rd && !do_wr) level <= level - LVL_ONE;
            if (bus.wr_valid && full) stall_seen <= 1'b1;
        end
    end

    // Storage needs no reset: empty masks the output, so stale words are unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_stream_source_fifo.sv
// Randomised and directed bench for stream_source_fifo: a queue-based reference
// model predicts outputs and an independent negedge monitor scores them.
module tb_stream_source_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stream_source_fifo_if #(.DATA_WIDTH(DW)) bus ();

    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic [15:0]   xfer_count;
    logic          stall_seen;

    stream_source_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .xfer_count (xfer_count),
        .stall_seen (stall_seen)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            m_level = 0;
    logic [15:0]   m_xfer  = 16'd0;
    logic          m_stall = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_level = 0;
            m_xfer  = 16'd0;
            m_stall = 1'b0;
        end else begin
            bit w;
            bit r;
            w = bus.wr_valid && (m_level < DEPTH);
            r = bus.stream_in_ready && (m_level > 0);
            if (bus.wr_valid && (m_level == DEPTH)) m_stall = 1'b1;
            if (w) exp_q.push_back(bus.wr_data);
            if (r) m_xfer = m_xfer + 16'd1;
            m_level = m_level + int'(w) - int'(r);
        end
    end

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            check("level", 32'(level), 32'(m_level));
            check("wr_ready", 32'(bus.wr_ready), 32'(m_level != DEPTH));
            check("stream_in_valid", 32'(bus.stream_in_valid), 32'(m_level > 0));
            check("xfer_count", 32'(xfer_count), 32'(m_xfer));
            check("stall_seen", 32'(stall_seen), 32'(m_stall));
            if (prev_stall) check("stall_hold_data", 32'(bus.stream_in_data), 32'(prev_data));
            if (bus.stream_in_valid && bus.stream_in_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no word at %0t",
                             bus.stream_in_data, $time);
                end else begin
                    check("out_data", 32'(bus.stream_in_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = bus.stream_in_valid && !bus.stream_in_ready;
            prev_data  = bus.stream_in_data;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1: apply inputs, let one edge pass, return at posedge+1.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy);
        bus.wr_valid        = v;
        bus.wr_data         = d;
        bus.stream_in_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_valid", 32'(bus.stream_in_valid), 32'd0);
        check("rst_data", 32'(bus.stream_in_data), 32'd0);
        check("rst_xfer", 32'(xfer_count), 32'd0);
        check("rst_stall", 32'(stall_seen), 32'd0);
    endtask

    // Reset asserted between edges; v/d are presented for the first edge after release.
    task automatic do_reset(input logic v, input logic [DW-1:0] d);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        #2;
        reset               = 1'b0;
        bus.wr_valid        = v;
        bus.wr_data         = d;
        bus.stream_in_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.wr_valid        = 1'b0;
        bus.stream_in_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 4 && !empty; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.wr_valid        = 1'b0;
        bus.wr_data         = '0;
        bus.stream_in_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0, '0);

        // single word
        cycle(1'b1, 8'hA5, 1'b0);
        check("single_valid", 32'(bus.stream_in_valid), 32'd1);
        check("single_data", 32'(bus.stream_in_data), 32'hA5);
        check("single_level", 32'(level), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        check("single_empty", 32'(empty), 32'd1);
        check("single_xfer", 32'(xfer_count), 32'd1);

        // fill and overflow
        do_reset(1'b0, '0);
        for (int k = 1; k <= 5; k++) cycle(1'b1, 8'(k), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("fill_stall", 32'(stall_seen), 32'd1);
        check("fill_level", 32'(level), 32'(DEPTH));
        check("fill_head", 32'(bus.stream_in_data), 32'h01);
        drain();

        // streaming
        do_reset(1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(i), 1'b1);
            check("stream_level", 32'(level), 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        check("stream_xfer", 32'(xfer_count), 32'd20);
        check("stream_empty", 32'(empty), 32'd1);

        // wrap-around with random stalls
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 3)) cycle(1'b0, 8'h00, 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
        end
        check("wrap_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        drain();

        // reset mid-operation
        do_reset(1'b0, '0);
        for (int k = 0; k < 3; k++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0);
        check("mid_level", 32'(level), 32'd3);
        do_reset(1'b1, 8'h3C);
        check("post_rst_valid", 32'(bus.stream_in_valid), 32'd1);
        check("post_rst_data", 32'(bus.stream_in_data), 32'h3C);
        check("post_rst_level", 32'(level), 32'd1);
        drain();

        // transfer counter wrap: exactly 65536 reads
        do_reset(1'b0, '0);
        for (int i = 0; i < 65536; i++) cycle(1'b1, 8'(i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("xfer_wrap", 32'(xfer_count), 32'd0);
        check("xfer_wrap_empty", 32'(empty), 32'd1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/stream_source_fifo.md
STREAM_SOURCE_FIFO -- requirements
Module: stream_source_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of storage entries; legal values are powers of two >= 2.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 The block SHALL have port wr_ready  output  1  block accepts wr_data this cycle.
REQ-007 The block SHALL have port wr_data  input  DATA_WIDTH  producer payload.
REQ-008 The block SHALL have port stream_in_valid  output  1  head entry is valid toward the downstream stage.
REQ-009 The block SHALL have port stream_in_ready  input  1  downstream stage accepts the head entry this cycle.
REQ-010 The block SHALL have port stream_in_data  output  DATA_WIDTH  head entry payload.
REQ-011 The block SHALL have port level  output  clog2(DEPTH)+1  current number of stored entries.
REQ-012 The block SHALL have port full  output  1  level == DEPTH.
REQ-013 The block SHALL have port empty  output  1  level == 0.
REQ-014 The block SHALL have port xfer_count  output  16  number of completed downstream transfers, modulo 2^16.
REQ-015 The block SHALL have port stall_seen  output  1  sticky flag: wr_valid was asserted while full.

Function
REQ-016 A write SHALL occur on a clock edge where wr_valid && wr_ready; a read SHALL occur on a clock edge where stream_in_valid && stream_in_ready.
REQ-017 wr_ready SHALL equal !full, combinationally from registered state; wr_ready SHALL NOT depend on stream_in_ready.
REQ-018 stream_in_valid SHALL equal !empty; stream_in_data SHALL present the oldest stored entry (first-word fall-through).
REQ-019 A word written at edge N SHALL be visible on stream_in_data with stream_in_valid high from edge N onward when the FIFO was empty: one-cycle write-to-output latency.
REQ-020 While stream_in_valid && !stream_in_ready, stream_in_data SHALL remain unchanged.
REQ-021 Simultaneous write and read SHALL leave level unchanged and preserve FIFO order.
REQ-022 Write and read pointers SHALL be clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 without gaps.
REQ-023 level SHALL increment on write-only, decrement on read-only, and hold otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-024 When full, wr_valid SHALL be ignored and no stored data SHALL be overwritten, even if a read occurs in the same cycle.
REQ-025 xfer_count SHALL increment by 1 per read and wrap from 16'hFFFF to 16'h0000.
REQ-026 stall_seen SHALL set on any edge where wr_valid && full and SHALL remain set until reset.
REQ-027 The datapath SHALL be DATA_WIDTH bits wide end to end with no truncation or sign extension.

Reset
REQ-028 Asserting reset SHALL immediately, without a clock edge, force level=0, empty=1, full=0, wr_ready=1, stream_in_valid=0, stream_in_data=0, xfer_count=0, stall_seen=0, and both pointers to 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; no pre-reset word SHALL appear after reset releases.
REQ-030 The first write SHALL be accepted on the first rising clk edge after reset deasserts.

Verification
REQ-031 Single word: reset, write 8'hA5 with stream_in_ready=0 -> next cycle stream_in_valid=1, stream_in_data=8'hA5, level=1; then stream_in_ready=1 -> empty=1, xfer_count=1.
REQ-032 Fill and overflow: with stream_in_ready=0, write 8'h01..8'h05 back-to-back -> first four accepted, full=1, wr_ready=0, stall_seen=1; drain yields 01,02,03,04 only.
REQ-033 Streaming: wr_valid=1 and stream_in_ready=1 continuously for 20 cycles with incrementing data 0..19 -> output in order 0..19, level constant at 1 after the first cycle, xfer_count=20.
REQ-034 Wrap-around: perform 10 write/read pairs alternating with random stream_in_ready stalls -> output order matches input order across pointer wrap; data stable during every stall.
REQ-035 Reset mid-operation: with level=3, assert reset between clock edges -> outputs reach reset values before the next edge; after release, write 8'h3C -> only 8'h3C appears at the output.
REQ-036 Counter wrap: force 65536 reads -> xfer_count returns to 16'h0000.
